jt1942_dwnld: RTL and testbench
===============================

// Module: jt1942_dwnld
// PURPOSE
//  Download-stage converter between the MiST ioctl byte stream and the SDRAM programming port.
//  Sits upstream of the SDRAM writer in jtframe_mist; consumes ioctl_addr/data/wr and produces prog_addr/data/mask/we.
//  Bytes below PROM_START go to SDRAM through a 2-entry buffer with an ack handshake.
//  Bytes at or above PROM_START are diverted to on-chip 256x4 colour/lookup PROMs.
// PARAMETERS
//  PROM_START  22'h1_4000  first ioctl byte address of the PROM region
//  PROM_CNT    8           number of 256x4 PROMs, selected by (addr-PROM_START)>>8
// PORTS
//  clk          in   1   system clock (48 MHz)
//  rst_n        in   1   asynchronous, active-low reset
//  downloading  in   1   ROM download in progress
//  ioctl_addr   in   22  byte address from io controller
//  ioctl_data   in   8   byte data
//  ioctl_wr     in   1   one-cycle byte strobe
//  prog_addr    out  22  SDRAM word address (ioctl_addr>>1)
//  prog_data    out  8   byte to write, replicated on both lanes by the writer
//  prog_mask    out  2   active-low byte mask: 2'b10 = low byte (even addr), 2'b01 = high byte (odd addr)
//  prog_we      out  1   write request; held until prog_ack
//  prog_ack     in   1   one-cycle acceptance from SDRAM writer
//  prom_we      out  PROM_CNT  one-hot one-cycle PROM write strobe
//  prom_addr    out  8   PROM address, (addr-PROM_START)[7:0]
//  prom_din     out  4   ioctl_data[3:0]
//  dwnld_done   out  1   one-cycle pulse when download finished and buffer drained
//  overflow     out  1   sticky: a byte was dropped because the buffer was full
//  checksum     out  16  running byte sum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0. Buffer empty, FSM IDLE, overflow clear.
//  - Writes are accepted only when ioctl_wr && downloading; ioctl_wr outside a download is ignored.
//  - FSM IDLE -> LOAD on the rising edge of downloading; overflow and checksum clear on that edge.
//  - LOAD -> DRAIN when downloading falls.
//  - DRAIN -> IDLE when the buffer is empty and prog_we is low; dwnld_done pulses for 1 cycle on that transition.
//  - SDRAM path: 2-entry FIFO of {addr,data,mask}.
//    - Byte strobed at cycle N with FIFO empty and prog_we low: prog_* valid and prog_we=1 at N+1.
//    - prog_we stays 1 with stable prog_addr/data/mask until the cycle after prog_ack.
//    - The next entry is presented in that same cycle, so back-to-back acks sustain 1 word/cycle.
//    - Push and pop in the same cycle with the FIFO full: the push is accepted.
//    - Push with the FIFO full and no pop: byte dropped, overflow=1 until the next download start.
//  - PROM path (ioctl_addr >= PROM_START):
//    - idx = (ioctl_addr-PROM_START)>>8.
//    - If idx < PROM_CNT: prom_we[idx]=1 for exactly cycle N+1 with prom_addr/prom_din registered; FIFO untouched.
//    - If idx >= PROM_CNT: the byte is discarded silently.
//  - The PROM path never stalls and never sets overflow.
//  - prog_ack while prog_we=0 is ignored.
//  - downloading falling with entries pending: entries still drain; dwnld_done waits for the last ack.
//  - rst_n low mid-transfer: FIFO flushed, prog_we drops asynchronously; no done pulse.
// CONFIGURATION
//  - JT1942_DWNLD_CHECKSUM_EN defined:
//    - checksum = 16-bit wrapping sum of every accepted byte (both paths, dropped bytes excluded).
//    - Updated the cycle after the strobe; cleared at download start.
//  - Undefined: checksum tied to 16'd0; no adder is synthesised.
// TESTING
//  - Download bytes 0x11,0x22 at addr 0,1, acking each at once:
//    - prog_addr 0 twice; masks 2'b10 then 2'b01; data 0x11,0x22.
//    - Lower downloading: dwnld_done pulses once.
//  - Hold prog_ack low, strobe 3 bytes:
//    - First byte stays on prog_*; third byte dropped, overflow=1.
//    - Ack twice: bytes 1,2 only.
//  - Strobe addr PROM_START+0x105, data 0xA7: prom_we=8'b0000_0010, prom_addr=0x05, prom_din=0x7 for 1 cycle; prog_we stays 0.
//  - Strobe addr PROM_START+0x800: no prom_we bit, no prog_we, overflow unchanged.
//  - Assert rst_n=0 with 2 entries pending: prog_we=0 at once; after release no done pulse and no stale write.
//  - With JT1942_DWNLD_CHECKSUM_EN defined, 0xFF,0xFF,0x03: checksum=16'h0201. Undefined: 0.

Source files
------------

// File: rtl/jt1942_dwnld.sv
// jt1942_dwnld
//   Converts the MiST ioctl byte stream into SDRAM programming writes.
//   It also diverts the PROM region into on-chip 256x4 PROM write strobes.
//
//   Bytes below PROM_START are queued in a 2-entry buffer. The head entry is
//   presented on prog_* and is held until prog_ack. Bytes at or above
//   PROM_START produce a one-cycle strobe on prom_we[idx].
//
// Parameters
//   PROM_START  first ioctl byte address of the PROM region
//   PROM_CNT    number of 256x4 PROMs
//
// Ports
//   clk, rst_n                  system clock, async active-low reset
//   downloading                 ROM download in progress
//   ioctl_addr/data/wr          byte stream from the io controller
//   prog_addr/data/mask/we      SDRAM write request (word address, active-low byte mask)
//   prog_ack                    one-cycle acceptance from the SDRAM writer
//   prom_we/addr/din            PROM write port (prom_we is one-hot)
//   dwnld_done                  one-cycle pulse once the download ended and the buffer drained
//   overflow                    sticky: a byte was dropped because the buffer was full
//   checksum                    running byte sum
//
// Build option
//   JT1942_DWNLD_CHECKSUM_EN    when defined, checksum is a 16-bit wrapping sum of accepted
//                               bytes, cleared at download start. Otherwise it is tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | no download; waiting for the rising edge of downloading
// ST_LOAD  | download active; bytes are accepted
// ST_DRAIN | download ended; waiting for the buffer to empty

module jt1942_dwnld #(
    parameter logic [21:0] PROM_START = 22'h1_4000,
    parameter int          PROM_CNT   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [21:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    input  logic                ioctl_wr,
    output logic [21:0]         prog_addr,
    output logic [7:0]          prog_data,
    output logic [1:0]          prog_mask,
    output logic                prog_we,
    input  logic                prog_ack,
    output logic [PROM_CNT-1:0] prom_we,
    output logic [7:0]          prom_addr,
    output logic [3:0]          prom_din,
    output logic                dwnld_done,
    output logic                overflow,
    output logic [15:0]         checksum
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [13:0] PROM_CNT_W = 14'(PROM_CNT);

    // Buffer entry layout: {word address[21:0], data[7:0], mask[1:0]}
    state_t                state_q, state_d;
    logic                  dl_q;
    logic [1:0]            cnt_q, cnt_d;
    logic [31:0]           head_q, head_d;
    logic [31:0]           spare_q, spare_d;
    logic                  prog_we_q, prog_we_d;
    logic [PROM_CNT-1:0]   prom_we_q, prom_we_d;
    logic [7:0]            prom_addr_q, prom_addr_d;
    logic [3:0]            prom_din_q, prom_din_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;

    logic                  dl_rise;
    logic                  wr_ok;
    logic                  is_prom;
    logic [21:0]           prom_off;
    logic [13:0]           prom_idx;
    logic                  prom_hit;
    logic                  sd_push;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic [31:0]           new_entry;

    always_comb begin
        dl_rise   = downloading & ~dl_q;
        wr_ok     = ioctl_wr & downloading;
        is_prom   = ioctl_addr >= PROM_START;
        prom_off  = ioctl_addr - PROM_START;
        prom_idx  = prom_off[21:8];
        prom_hit  = wr_ok & is_prom & (prom_idx < PROM_CNT_W);
        sd_push   = wr_ok & ~is_prom;
        pop       = prog_we_q & prog_ack;
        // A full buffer still takes the byte when the head leaves in the same cycle.
        push_ok   = sd_push & ((cnt_q != 2'd2) | pop);
        drop      = sd_push & ~push_ok;
        new_entry = {1'b0, ioctl_addr[21:1], ioctl_data,
                     ioctl_addr[0] ? 2'b01 : 2'b10};
    end

    // Two-entry buffer: head_q drives prog_*, and spare_q holds the next entry.
    always_comb begin
        head_d  = head_q;
        spare_d = spare_q;
        cnt_d   = cnt_q;
        case ({push_ok, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d  = new_entry;
                else               spare_d = new_entry;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) head_d = spare_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = new_entry;
                end else begin
                    head_d  = spare_q;
                    spare_d = new_entry;
                end
            end
            default: ;
        endcase
        prog_we_d = (cnt_d != 2'd0);
    end

    always_comb begin
        prom_we_d   = '0;
        prom_addr_d = prom_addr_q;
        prom_din_d  = prom_din_q;
        if (prom_hit) begin
            for (int i = 0; i < PROM_CNT; i++) begin
                if (prom_idx == 14'(i)) prom_we_d[i] = 1'b1;
            end
            prom_addr_d = prom_off[7:0];
            prom_din_d  = ioctl_data[3:0];
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE:  if (dl_rise) state_d = ST_LOAD;
            ST_LOAD:  if (!downloading) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if ((cnt_q == 2'd0) && !prog_we_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        overflow_d = (dl_rise ? 1'b0 : overflow_q) | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dl_q        <= 1'b0;
            cnt_q       <= 2'd0;
            head_q      <= '0;
            spare_q     <= '0;
            prog_we_q   <= 1'b0;
            prom_we_q   <= '0;
            prom_addr_q <= '0;
            prom_din_q  <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_q        <= downloading;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            spare_q     <= spare_d;
            prog_we_q   <= prog_we_d;
            prom_we_q   <= prom_we_d;
            prom_addr_q <= prom_addr_d;
            prom_din_q  <= prom_din_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef JT1942_DWNLD_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Only bytes that actually landed somewhere are summed.
    // Dropped bytes and out-of-range PROM bytes are excluded.
    always_comb begin
        csum_d = (dl_rise ? 16'd0 : csum_q)
               + ((push_ok | prom_hit) ? {8'd0, ioctl_data} : 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= 16'd0;
        else        csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = 16'd0;
`endif

    assign prog_addr  = head_q[31:10];
    assign prog_data  = head_q[9:2];
    assign prog_mask  = head_q[1:0];
    assign prog_we    = prog_we_q;
    assign prom_we    = prom_we_q;
    assign prom_addr  = prom_addr_q;
    assign prom_din   = prom_din_q;
    assign dwnld_done = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_jt1942_dwnld.sv
module tb_jt1942_dwnld;

    localparam logic [21:0] PS = 22'h1_4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_ack = 1'b0;
    logic [7:0]  prom_we;
    logic [7:0]  prom_addr;
    logic [3:0]  prom_din;
    logic        dwnld_done;
    logic        overflow;
    logic [15:0] checksum;

    jt1942_dwnld dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_ack(prog_ack),
        .prom_we(prom_we), .prom_addr(prom_addr), .prom_din(prom_din),
        .dwnld_done(dwnld_done), .overflow(overflow), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int ack_budget = 0;
    int exp_done = 0;
    int done_seen = 0;
    logic [31:0] sdq[$];     // {word addr, data, mask}
    logic [19:0] promq[$];   // {prom_we, prom_addr, prom_din}

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // SDRAM writer model: acks while budget remains, and checks each accepted word.
    always @(negedge clk) begin
        logic [31:0] want;
        if (rst_n && prog_we && ack_budget > 0) begin
            checks++;
            if (sdq.size() == 0) begin
                fails++;
                $display("FAIL sdram_unexpected: got %0h/%0h/%0h expected none",
                         prog_addr, prog_data, prog_mask);
            end else begin
                want = sdq.pop_front();
                if ({prog_addr, prog_data, prog_mask} !== want) begin
                    fails++;
                    $display("FAIL sdram_word: got %0h expected %0h",
                             {prog_addr, prog_data, prog_mask}, want);
                end
            end
            prog_ack = 1'b1;
            ack_budget--;
        end else begin
            prog_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [19:0] want;
        if (prom_we != 8'd0) begin
            checks++;
            if (promq.size() == 0) begin
                fails++;
                $display("FAIL prom_unexpected: got %0h expected none", {prom_we, prom_addr, prom_din});
            end else begin
                want = promq.pop_front();
                if ({prom_we, prom_addr, prom_din} !== want) begin
                    fails++;
                    $display("FAIL prom_write: got %0h expected %0h", {prom_we, prom_addr, prom_din}, want);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (dwnld_done) begin
            checks++;
            done_seen++;
            if (exp_done == 0) begin
                fails++;
                $display("FAIL done_unexpected: got pulse expected none");
            end else begin
                exp_done--;
            end
        end
    end

    task automatic strobe(input logic [21:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_dl();
        @(posedge clk); #1;
        downloading = 1'b1;
        cycles(2);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((prog_we || sdq.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_we_low"}, {31'd0, prog_we}, 32'd0);
        check({nm, "_all_acked"}, sdq.size(), 32'd0);
    endtask

    task automatic end_dl(input string nm, input int target);
        int n = 0;
        exp_done = exp_done + 1;
        @(posedge clk); #1;
        downloading = 1'b0;
        while (done_seen < target && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, done_seen, target);
        cycles(3);
    endtask

    initial begin
        // reset values
        #12;
        check("rst_prog_we", {31'd0, prog_we}, 0);
        check("rst_prog_addr", {10'd0, prog_addr}, 0);
        check("rst_prom_we", {24'd0, prom_we}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_done", {31'd0, dwnld_done}, 0);
        check("rst_checksum", {16'd0, checksum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // two bytes acked at once, then done
        start_dl();
        ack_budget = 1000;
        sdq.push_back({22'd0, 8'h11, 2'b10});
        sdq.push_back({22'd0, 8'h22, 2'b01});
        strobe(22'd0, 8'h11);
        check("lat_prog_we", {31'd0, prog_we}, 1);
        check("lat_prog_mask", {30'd0, prog_mask}, 32'd2);
        check("lat_prog_data", {24'd0, prog_data}, 32'h11);
        strobe(22'd1, 8'h22);
        wait_drain("t1");
        end_dl("t1_done", 1);

        // full buffer drops the third byte
        start_dl();
        ack_budget = 0;
        sdq.push_back({22'h8, 8'hA1, 2'b10});
        sdq.push_back({22'h8, 8'hA2, 2'b01});
        strobe(22'h10, 8'hA1);
        strobe(22'h11, 8'hA2);
        strobe(22'h12, 8'hA3);
        check("ovf_set", {31'd0, overflow}, 1);
        cycles(3);
        check("ovf_hold_we", {31'd0, prog_we}, 1);
        check("ovf_hold_addr", {10'd0, prog_addr}, 32'h8);
        check("ovf_hold_data", {24'd0, prog_data}, 32'hA1);
        ack_budget = 2;
        wait_drain("t2");
        check("ovf_sticky", {31'd0, overflow}, 1);
        end_dl("t2_done", 2);

        // PROM path
        start_dl();
        check("ovf_cleared", {31'd0, overflow}, 0);
        ack_budget = 1000;
        promq.push_back({8'h02, 8'h05, 4'h7});
        strobe(PS + 22'h105, 8'hA7);
        check("prom_strobe", {24'd0, prom_we}, 32'h02);
        check("prom_no_prog", {31'd0, prog_we}, 0);
        cycles(1);
        check("prom_one_cycle", {24'd0, prom_we}, 0);
        strobe(PS + 22'h800, 8'h55);
        check("prom_oor_we", {24'd0, prom_we}, 0);
        check("prom_oor_prog", {31'd0, prog_we}, 0);
        check("prom_oor_ovf", {31'd0, overflow}, 0);
        promq.push_back({8'h80, 8'hFF, 4'hC});
        strobe(PS + 22'h7FF, 8'h3C);
        sdq.push_back({22'h9FFF, 8'h5A, 2'b01});
        strobe(PS - 22'd1, 8'h5A);
        wait_drain("t3");
        cycles(2);
        check("prom_all_seen", promq.size(), 0);
        end_dl("t3_done", 3);

        // checksum
        start_dl();
        sdq.push_back({22'h10, 8'hFF, 2'b10});
        sdq.push_back({22'h10, 8'hFF, 2'b01});
        sdq.push_back({22'h11, 8'h03, 2'b10});
        strobe(22'h20, 8'hFF);
        strobe(22'h21, 8'hFF);
        strobe(22'h22, 8'h03);
        wait_drain("t4");
`ifdef JT1942_DWNLD_CHECKSUM_EN
        check("checksum", {16'd0, checksum}, 32'h0201);
`else
        check("checksum", {16'd0, checksum}, 32'h0);
`endif

        // reset with entries pending; download still active
        ack_budget = 0;
        strobe(22'h30, 8'h01);
        strobe(22'h31, 8'h02);
        check("prerst_we", {31'd0, prog_we}, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_we", {31'd0, prog_we}, 0);
        downloading = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        ack_budget = 1000;
        cycles(10);
        check("postrst_we", {31'd0, prog_we}, 0);
        check("postrst_no_done", done_seen, 3);
        strobe(22'h40, 8'h77);
        check("idle_strobe_ignored", {31'd0, prog_we}, 0);
        cycles(5);

        check("sdq_empty", sdq.size(), 0);
        check("exp_done_zero", exp_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
